pixel_frame_gate: RTL and testbench
===================================

# pixel_frame_gate

Upstream stage of `histogram_module`. Accepts the raw camera stream (`frame_valid`/`line_valid`/`pixel_data`) on `clk` and passes exactly one complete frame per arm pulse from the fsin-derived enable. Optionally crops the frame to a region of interest. Checks each frame's line and row geometry, and reports a frame count and completion pulse. Its outputs drive the histogram inputs directly, so partial frames never reach the histogram.

## Interface
- `PIXEL_W`, 10: pixel data width.
- `EXP_COLS`, 1920: expected pixels per line.
- `EXP_ROWS`, 1280: expected lines per frame.
- `CNT_W`, 12: column and row counter width; must hold `EXP_COLS` and `EXP_ROWS`.
- `clk` in 1: pixel clock, 125 MHz.
- `reset` in 1: asynchronous, active-high.
- `en` in 1: arm request; a single-cycle pulse, one per fsin.
- `frame_valid_i` in 1: camera frame valid.
- `line_valid_i` in 1: camera line valid.
- `pixel_data_i` in `PIXEL_W`: camera pixel.
- `roi_x0`, `roi_x1`, `roi_y0`, `roi_y1` in `CNT_W` each: inclusive ROI bounds, 0-based.
- `frame_valid_o` out 1: gated frame valid, to histogram.
- `line_valid_o` out 1: gated line valid, to histogram.
- `pixel_data_o` out `PIXEL_W`: gated pixel.
- `frame_done` out 1: single-cycle pulse at the end of each passed frame.
- `frame_count` out 16: number of passed frames.
- `geom_err` out 2: bit0 = column mismatch, bit1 = row mismatch.

## Operation
- States:
  - `IDLE`: not armed.
  - `SYNC`: armed while `frame_valid_i` was high; waits for it to go low.
  - `WAIT_SOF`: armed; waits for a rising edge of `frame_valid_i`.
  - `FRAME`: passing the frame.
- Transitions:
  - `IDLE` + `en`: go to `WAIT_SOF` if `frame_valid_i` is 0, otherwise to `SYNC`.
  - `SYNC` → `WAIT_SOF` when `frame_valid_i` is 0.
  - `WAIT_SOF` → `FRAME` on a rising edge of `frame_valid_i`.
  - `FRAME` → `WAIT_SOF` on the falling edge of `frame_valid_i` if `arm_pending` is set, otherwise → `IDLE`.
- `en` during `SYNC`, `WAIT_SOF` or `FRAME` sets `arm_pending`. It is cleared on entry to `FRAME`. Multiple pulses collapse into one.
- In `FRAME`:
  - `col` counts cycles with `frame_valid_i & line_valid_i`. It resets to 0 on the falling edge of `line_valid_i` and saturates at all-ones.
  - `row` increments on each falling edge of `line_valid_i`.
  - `line_valid_i` while `frame_valid_i` is low is ignored and not counted.
- Column check: on each falling edge of `line_valid_i`, if `col != EXP_COLS`, set `geom_err[0]`.
- Row check: on the falling edge of `frame_valid_i`, if `row != EXP_ROWS`, set `geom_err[1]`. A line still open when `frame_valid_i` falls counts as a row and is column-checked.
- `geom_err` is sticky. It clears on entry to `FRAME`.
- `frame_count` increments, with 16-bit wrap, in the same cycle as `frame_done`.
- Outside `FRAME`, all outputs are held low, `pixel_data_o` included.

## Timing
- All outputs are registered. Latency from input to `*_o` is 1 cycle.
- `frame_valid_o` rises 1 cycle after the rising edge of `frame_valid_i` that causes entry to `FRAME`. It falls 1 cycle after `frame_valid_i` falls.
- `frame_done` is high in the same cycle that `frame_valid_o` first reads 0.
- Edge detection uses a 1-cycle delayed copy of each valid input. The inputs are synchronous to `clk`; no synchronizer is used.
- Reset values: all outputs 0, state `IDLE`, `arm_pending` 0, counters 0.
- Reset mid-frame: outputs go to 0 immediately (asynchronous). After release, the block needs a fresh `en`.
- `en` in the same cycle as a rising edge of `frame_valid_i` while in `IDLE`: the block goes to `SYNC` and that frame is skipped.

## Configuration
- `PIXEL_FRAME_GATE_ROI_EN` defined:
  - `line_valid_o` is high only for pixels with `roi_x0 <= col <= roi_x1` and `roi_y0 <= row <= roi_y1`.
  - `pixel_data_o` is 0 elsewhere.
  - The ROI registers are sampled on entry to `FRAME` and held for the rest of the frame.
- Macro undefined: the full frame passes. The ROI ports remain present and are ignored.
- The geometry check is identical in both builds and always uses the uncropped counts.

## Structure
- Shared package `pixel_pkg`:
  - `PIXEL_W`.
  - `CNT_W`.
  - the state enum `gate_state_t` (`IDLE`, `SYNC`, `WAIT_SOF`, `FRAME`).
  - `geom_err` bit index constants.
- One sub-module, `line_frame_counter`. It performs edge detection, `col`/`row` counting and saturation, and the geometry compare. It outputs `col`, `row`, `sol`, `eol`, `sof`, `eof` and the error strobes.

## Test plan
All scenarios use `EXP_COLS=8`, `EXP_ROWS=4`.
- Arm with `en`, then send a 4×8 frame of ramp pixels. Expect `frame_valid_o` to mirror the frame 1 cycle late with 32 valid pixels, `frame_done` for 1 cycle, `frame_count=1`, `geom_err=0`.
- Send a frame with no `en`. Expect the outputs to stay at 0 and `frame_count` to remain unchanged.
- Pulse `en` mid-frame. Expect that frame to be blocked, the next full frame to pass, and `frame_count` to increment by 1.
- Send a frame with line 2 of 7 pixels and only 3 lines. Expect `geom_err=2'b11` after `frame_done`, cleared when the next passed frame starts.
- With ROI on, `x0=2`, `x1=5`, `y0=1`, `y1=2`: expect `line_valid_o` high for 8 pixels total, `pixel_data_o` 0 elsewhere, and `frame_valid_o` unchanged.
- Assert `reset` at pixel 13 of a frame. Expect all outputs 0 in the same cycle and no pass after release until a new `en`.

Source files
------------

// File: rtl/pixel_frame_gate_pkg.sv
// Shared types and constants for the pixel frame gate and its line/frame counter.
package pixel_pkg;

    localparam int PIXEL_W = 10;
    localparam int CNT_W   = 12;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        WAIT_SOF,
        FRAME
    } gate_state_t;

    localparam int GEOM_COL_BIT = 0;
    localparam int GEOM_ROW_BIT = 1;

endpackage

// File: rtl/pixel_frame_gate_if.sv
// Camera-side stream into the gate and the gated stream out to the histogram.
interface pixel_frame_gate_if;
    import pixel_pkg::*;

    logic               frame_valid_i;
    logic               line_valid_i;
    logic [PIXEL_W-1:0] pixel_data_i;
    logic               frame_valid_o;
    logic               line_valid_o;
    logic [PIXEL_W-1:0] pixel_data_o;

    modport master (
        output frame_valid_i, line_valid_i, pixel_data_i,
        input  frame_valid_o, line_valid_o, pixel_data_o
    );

    modport slave (
        input  frame_valid_i, line_valid_i, pixel_data_i,
        output frame_valid_o, line_valid_o, pixel_data_o
    );

endinterface

// File: rtl/pixel_frame_gate_line_frame_counter.sv
// Edge detection, column/row counting and geometry compare for one passed frame.
module line_frame_counter
    import pixel_pkg::*;
#(
    parameter int EXP_COLS = 1920,
    parameter int EXP_ROWS = 1280
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_valid,
    input  logic             line_valid,
    input  logic             start,
    input  logic             active,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             sol,
    output logic             eol,
    output logic             sof,
    output logic             eof,
    output logic             col_err,
    output logic             row_err
);

    localparam logic [CNT_W-1:0] COL_MAX    = '1;
    localparam logic [CNT_W-1:0] EXP_COLS_C = CNT_W'(EXP_COLS);
    localparam logic [CNT_W-1:0] EXP_ROWS_C = CNT_W'(EXP_ROWS);

    logic             fv_d;
    logic             lv_d;
    logic             lv_q;
    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] row_end;

    // A line only exists inside the frame, so a frame falling edge also closes an open line.
    assign lv_q = frame_valid & line_valid;
    assign sof  = frame_valid & ~fv_d;
    assign eof  = ~frame_valid & fv_d;
    assign sol  = lv_q & ~lv_d;
    assign eol  = ~lv_q & lv_d;

    assign col = sol   ? '0 : col_q;
    assign row = start ? '0 : row_q;

    assign row_end = row_q + {{(CNT_W-1){1'b0}}, eol};
    assign col_err = active & eol & (col_q != EXP_COLS_C);
    assign row_err = active & eof & (row_end != EXP_ROWS_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fv_d <= 1'b0;
            lv_d <= 1'b0;
        end else begin
            fv_d <= frame_valid;
            lv_d <= lv_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (start) begin
            col_q <= lv_q ? CNT_W'(1) : '0;
            row_q <= '0;
        end else if (active) begin
            if (eol) begin
                col_q <= '0;
                row_q <= row_q + CNT_W'(1);
            end else if (lv_q && (col_q != COL_MAX)) begin
                col_q <= col_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_frame_gate.sv
// Passes exactly one complete camera frame per arm pulse; optional ROI crop via PIXEL_FRAME_GATE_ROI_EN.
module pixel_frame_gate
    import pixel_pkg::*;
#(
    parameter int EXP_COLS = 1920,
    parameter int EXP_ROWS = 1280
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    pixel_frame_gate_if.slave cam,
    input  logic [CNT_W-1:0]  roi_x0,
    input  logic [CNT_W-1:0]  roi_x1,
    input  logic [CNT_W-1:0]  roi_y0,
    input  logic [CNT_W-1:0]  roi_y1,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic [1:0]        geom_err
);

    gate_state_t      state;
    gate_state_t      state_nx;
    logic             arm_pending;
    logic             arm_pending_nx;
    logic             start;
    logic             active;
    logic             pass;
    logic             roi_ok;
    logic             pix_ok;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             sol;
    logic             eol;
    logic             sof;
    logic             eof;
    logic             col_err;
    logic             row_err;
    logic             unused_sig;

    line_frame_counter #(
        .EXP_COLS (EXP_COLS),
        .EXP_ROWS (EXP_ROWS)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (cam.frame_valid_i),
        .line_valid  (cam.line_valid_i),
        .start       (start),
        .active      (active),
        .col         (col),
        .row         (row),
        .sol         (sol),
        .eol         (eol),
        .sof         (sof),
        .eof         (eof),
        .col_err     (col_err),
        .row_err     (row_err)
    );

    // The start cycle already passes its pixel, so outputs track the input with one register of delay.
    assign active = (state == FRAME);
    assign start  = (state == WAIT_SOF) && sof;
    assign pass   = active | start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            arm_pending <= 1'b0;
        end else begin
            state       <= state_nx;
            arm_pending <= arm_pending_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        arm_pending_nx = arm_pending;
        case (state)
            IDLE: begin
                if (en) state_nx = cam.frame_valid_i ? SYNC : WAIT_SOF;
            end
            SYNC: begin
                if (en) arm_pending_nx = 1'b1;
                if (!cam.frame_valid_i) state_nx = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (en) arm_pending_nx = 1'b1;
                if (sof) begin
                    state_nx       = FRAME;
                    arm_pending_nx = 1'b0;
                end
            end
            FRAME: begin
                if (en) arm_pending_nx = 1'b1;
                if (eof) state_nx = (arm_pending | en) ? WAIT_SOF : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef PIXEL_FRAME_GATE_ROI_EN
    logic [CNT_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [CNT_W-1:0] x0, x1, y0, y1;

    // Bounds are frozen at frame entry; the entry cycle itself uses the live ports.
    assign x0 = start ? roi_x0 : x0_q;
    assign x1 = start ? roi_x1 : x1_q;
    assign y0 = start ? roi_y0 : y0_q;
    assign y1 = start ? roi_y1 : y1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q <= '0;
            x1_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
        end else if (start) begin
            x0_q <= roi_x0;
            x1_q <= roi_x1;
            y0_q <= roi_y0;
            y1_q <= roi_y1;
        end
    end

    assign roi_ok     = (col >= x0) && (col <= x1) && (row >= y0) && (row <= y1);
    assign unused_sig = eol;
`else
    assign roi_ok     = 1'b1;
    assign unused_sig = ^{col, row, roi_x0, roi_x1, roi_y0, roi_y1, eol};
`endif

    assign pix_ok = pass & cam.frame_valid_i & cam.line_valid_i & roi_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cam.frame_valid_o <= 1'b0;
            cam.line_valid_o  <= 1'b0;
            cam.pixel_data_o  <= '0;
            frame_done        <= 1'b0;
            frame_count       <= '0;
        end else begin
            cam.frame_valid_o <= pass & cam.frame_valid_i;
            cam.line_valid_o  <= pix_ok;
            cam.pixel_data_o  <= pix_ok ? cam.pixel_data_i : '0;
            frame_done        <= active & eof;
            if (active && eof) frame_count <= frame_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            geom_err <= '0;
        end else if (start) begin
            geom_err <= '0;
        end else begin
            if (col_err) geom_err[GEOM_COL_BIT] <= 1'b1;
            if (row_err) geom_err[GEOM_ROW_BIT] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_frame_gate.sv
// Frame-table bench for pixel_frame_gate with a pixel scoreboard and per-cycle output model.
module tb_pixel_frame_gate;
    import pixel_pkg::*;

    localparam int EXP_COLS = 8;
    localparam int EXP_ROWS = 4;
`ifdef PIXEL_FRAME_GATE_ROI_EN
    localparam bit ROI_BUILD = 1'b1;
`else
    localparam bit ROI_BUILD = 1'b0;
`endif

    typedef struct {
        bit          en_before;
        int          en_at;
        int          rst_at;
        int          n_rows;
        int          short_line;
        int          short_cols;
        bit          roi;
        bit          exp_pass;
        int          exp_pixels;
        logic [15:0] exp_count;
        logic [1:0]  exp_err;
    } frame_vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [CNT_W-1:0] roi_x0, roi_x1, roi_y0, roi_y1;
    logic             frame_done;
    logic [15:0]      frame_count;
    logic [1:0]       geom_err;

    int                 checks = 0;
    int                 fails = 0;
    int                 rx_pixels = 0;
    bit                 window = 1'b0;
    bit                 exp_fv = 1'b0;
    bit                 exp_lv = 1'b0;
    logic [PIXEL_W-1:0] ramp = '0;
    logic [PIXEL_W-1:0] pix_q[$];

    pixel_frame_gate_if cam();

    pixel_frame_gate #(
        .EXP_COLS (EXP_COLS),
        .EXP_ROWS (EXP_ROWS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cam         (cam),
        .roi_x0      (roi_x0),
        .roi_x1      (roi_x1),
        .roi_y0      (roi_y0),
        .roi_y1      (roi_y1),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .geom_err    (geom_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " frame_valid_o"}, 32'(cam.frame_valid_o), 32'd0);
        check_output({tag, " line_valid_o"},  32'(cam.line_valid_o),  32'd0);
        check_output({tag, " pixel_data_o"},  32'(cam.pixel_data_o),  32'd0);
        check_output({tag, " frame_done"},    32'(frame_done),        32'd0);
        check_output({tag, " frame_count"},   32'(frame_count),       32'd0);
        check_output({tag, " geom_err"},      32'(geom_err),          32'd0);
    endtask

    function automatic bit roi_in(input bit roi, input int c, input int r);
        return !(ROI_BUILD && roi) || (c >= 2 && c <= 5 && r >= 1 && r <= 2);
    endfunction

    // Output side: each cycle compares against what the driver declared for the value it just drove.
    initial begin : monitor
        bit          fv_prev;
        bit          exp_done;
        logic [15:0] cnt_model;
        logic [PIXEL_W-1:0] want;
        fv_prev   = 1'b0;
        cnt_model = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                fv_prev   = 1'b0;
                cnt_model = '0;
            end else begin
                check_output("frame_valid_o", 32'(cam.frame_valid_o), 32'(exp_fv));
                check_output("line_valid_o",  32'(cam.line_valid_o),  32'(exp_lv));
                if (cam.line_valid_o) begin
                    rx_pixels++;
                    check_output("pixel_available", 32'(pix_q.size() != 0), 32'd1);
                    if (pix_q.size() != 0) begin
                        want = pix_q.pop_front();
                        check_output("pixel_data_o", 32'(cam.pixel_data_o), 32'(want));
                    end
                end else begin
                    check_output("pixel_data_o idle", 32'(cam.pixel_data_o), 32'd0);
                end
                exp_done = fv_prev & ~exp_fv;
                check_output("frame_done", 32'(frame_done), 32'(exp_done));
                if (exp_done) cnt_model = cnt_model + 16'd1;
                check_output("frame_count", 32'(frame_count), 32'(cnt_model));
                if (!fv_prev && exp_fv)
                    check_output("geom_err at frame start", 32'(geom_err), 32'd0);
                fv_prev = exp_fv;
            end
        end
    end

    // rst_op: 0 none, 1 assert reset this cycle, 2 release reset this cycle.
    task automatic drive_cycle(input bit fv, input bit lv, input bit pulse, input bit in_roi, input int rst_op);
        @(negedge clk);
        if (rst_op == 1) begin
            reset  = 1'b1;
            window = 1'b0;
            pix_q.delete();
        end else if (rst_op == 2) begin
            reset = 1'b0;
        end
        en                = pulse;
        cam.frame_valid_i = fv;
        cam.line_valid_i  = lv;
        cam.pixel_data_i  = ramp;
        exp_fv            = window & fv;
        exp_lv            = window & fv & lv & in_roi;
        if (exp_lv) pix_q.push_back(ramp);
        if (lv) ramp = ramp + 1'b1;
        if (rst_op == 1) begin
            #1;
            check_all_zero("mid-frame reset");
        end
    endtask

    task automatic apply_stimulus(input frame_vec_t v);
        int pix;
        int ncols;
        int rst_op;
        pix       = 0;
        rx_pixels = 0;
        window    = v.exp_pass;
        if (v.roi) begin
            roi_x0 = 12'd2; roi_x1 = 12'd5; roi_y0 = 12'd1; roi_y1 = 12'd2;
        end else begin
            roi_x0 = '0; roi_x1 = '1; roi_y0 = '0; roi_y1 = '1;
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, v.en_before && (i == 0), 1'b0, 0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int r = 0; r < v.n_rows; r++) begin
            ncols = (r == v.short_line) ? v.short_cols : EXP_COLS;
            for (int c = 0; c < ncols; c++) begin
                rst_op = (pix == v.rst_at) ? 1 : ((v.rst_at >= 0 && pix == v.rst_at + 2) ? 2 : 0);
                drive_cycle(1'b1, 1'b1, pix == v.en_at, roi_in(v.roi, c, r), rst_op);
                pix++;
            end
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
            if (v.roi && r == 0) begin
                roi_x0 = '0; roi_x1 = '0; roi_y0 = '0; roi_y1 = '0;
            end
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
        window = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin : main
        frame_vec_t vecs[13];
        int roi_pix;
        roi_pix = ROI_BUILD ? 8 : 32;
        //           en_b en_at rst  rows short scols roi pass pixels count   err
        vecs[0]  = '{1'b1, -1, -1, 4, -1, 8, 1'b0, 1'b1, 32,      16'd1, 2'b00};
        vecs[1]  = '{1'b0, -1, -1, 4, -1, 8, 1'b0, 1'b0, 0,       16'd1, 2'b00};
        vecs[2]  = '{1'b0, 10, -1, 4, -1, 8, 1'b0, 1'b0, 0,       16'd1, 2'b00};
        vecs[3]  = '{1'b0, -1, -1, 4, -1, 8, 1'b0, 1'b1, 32,      16'd2, 2'b00};
        vecs[4]  = '{1'b1, -1, -1, 3,  1, 7, 1'b0, 1'b1, 23,      16'd3, 2'b11};
        vecs[5]  = '{1'b1, -1, -1, 4, -1, 8, 1'b0, 1'b1, 32,      16'd4, 2'b00};
        vecs[6]  = '{1'b1, -1, -1, 4, -1, 8, 1'b1, 1'b1, roi_pix, 16'd5, 2'b00};
        vecs[7]  = '{1'b1, -1, 13, 4, -1, 8, 1'b0, 1'b1, 13,      16'd0, 2'b00};
        vecs[8]  = '{1'b0, -1, -1, 4, -1, 8, 1'b0, 1'b0, 0,       16'd0, 2'b00};
        vecs[9]  = '{1'b1, -1, -1, 4, -1, 8, 1'b0, 1'b1, 32,      16'd1, 2'b00};
        vecs[10] = '{1'b1,  5, -1, 4, -1, 8, 1'b0, 1'b1, 32,      16'd2, 2'b00};
        vecs[11] = '{1'b0, -1, -1, 4, -1, 8, 1'b0, 1'b1, 32,      16'd3, 2'b00};
        vecs[12] = '{1'b0, -1, -1, 4, -1, 8, 1'b0, 1'b0, 0,       16'd3, 2'b00};

        reset             = 1'b1;
        en                = 1'b0;
        cam.frame_valid_i = 1'b0;
        cam.line_valid_i  = 1'b0;
        cam.pixel_data_i  = '0;
        roi_x0 = '0; roi_x1 = '1; roi_y0 = '0; roi_y1 = '1;
        repeat (3) @(negedge clk);
        check_all_zero("reset state");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            $display("[TB] frame vector %0d", i);
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d frame_count", i), 32'(frame_count), 32'(vecs[i].exp_count));
            check_output($sformatf("vec%0d geom_err", i),    32'(geom_err),    32'(vecs[i].exp_err));
            check_output($sformatf("vec%0d pixels", i),      32'(rx_pixels),   32'(vecs[i].exp_pixels));
            check_output($sformatf("vec%0d queue empty", i), 32'(pix_q.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
